bcd_scan_mux: RTL and testbench

Parametrised N-channel, W-bit registered digit multiplexer for the BCD subtractor display path. It has two modes. Manual mode drives a selected channel. Auto-scan mode walks the channels round-robin, with a programmable dwell time and an anti-ghosting blank gap. It sits between the BCD result/operand registers and the seven-segment decoder, driving data plus a one-hot digit enable.

---
 rtl/bcd_disp_pkg.sv | 26 ++
 rtl/bcd_scan_mux_if.sv | 23 ++
 rtl/bcd_scan_timer.sv | 38 +++
 rtl/bcd_scan_mux.sv | 102 ++++++++++
 tb/tb_bcd_scan_mux.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and helpers for the BCD display path: scan FSM states,
// mode encodings, one-hot digit enable and a minimum-1 clog2 width helper.
package bcd_disp_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int MAX_SELW     = 4;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SHOW   = 2'd1,
        BLANK  = 2'd2
    } scan_state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of an index/counter covering n values, never less than one bit.
    function automatic int min1_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_CHANNELS-1:0] onehot(input logic [MAX_SELW-1:0] idx);
        return MAX_CHANNELS'(1) << idx;
    endfunction

endpackage

// File: rtl/bcd_scan_mux_if.sv
// Digit-mux bus: control and packed channel data toward the mux,
// registered digit, index, one-hot enable and advance pulse back.
interface bcd_scan_mux_if
    import bcd_disp_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SELW = min1_clog2(CHANNELS);

    logic                      mode;
    logic [SELW-1:0]           sel;
    logic                      hold;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [WIDTH-1:0]          y;
    logic [SELW-1:0]           ch;
    logic [CHANNELS-1:0]       en;
    logic                      tick;

    modport master (output mode, sel, hold, data_in, input  y, ch, en, tick);
    modport slave  (input  mode, sel, hold, data_in, output y, ch, en, tick);

endinterface

// File: rtl/bcd_scan_timer.sv
// Dwell/blank counter for the scan FSM; done flags the last cycle of the
// current show or blank interval.
module bcd_scan_timer #(
    parameter int CNTW         = 16,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic freeze,
    input  logic blanking,
    output logic done
);
    localparam logic [CNTW-1:0] SHOW_LAST  = CNTW'(PRESCALE - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic [CNTW-1:0] cnt;

    always_comb begin
        done = (cnt == (blanking ? BLANK_LAST : SHOW_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (freeze) begin
            cnt <= cnt;
        end else if (done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_scan_mux.sv
// N-channel registered digit multiplexer with manual select and
// round-robin auto-scan including an anti-ghosting blank gap.
module bcd_scan_mux
    import bcd_disp_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CHANNELS     = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_scan_mux_if.slave bus
);
    localparam int SELW    = min1_clog2(CHANNELS);
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNTW    = min1_clog2(CNT_MAX);

    localparam logic [1:0] S_MANUAL = 2'(MANUAL);
    localparam logic [1:0] S_SHOW   = 2'(SHOW);
    localparam logic [1:0] S_BLANK  = 2'(BLANK);

    localparam logic [SELW-1:0] LAST_CH  = SELW'(CHANNELS - 1);
    localparam logic [SELW:0]   CH_LIMIT = (SELW + 1)'(CHANNELS);

    logic [1:0]      state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] next_ptr;
    logic            sel_ok;
    logic            to_manual;
    logic            advance;
    logic            done;

    // NOTE: every variable gets a value on every path here, so no latch can form.
    always_comb begin
        sel_ok    = ({1'b0, bus.sel} < CH_LIMIT);
        to_manual = (bus.mode == MODE_MANUAL);
        advance   = (state == S_SHOW) && !to_manual && !bus.hold && done;
        next_ptr  = (ptr == LAST_CH) ? '0 : ptr + 1'b1;
    end

    // Leaving scan clears the counter so a return to scan starts a full dwell.
    bcd_scan_timer #(
        .CNTW         (CNTW),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    ((state == S_MANUAL) || to_manual),
        .freeze   ((state == S_SHOW) && bus.hold),
        .blanking (state == S_BLANK),
        .done     (done)
    );

    // NOTE: state uses non-blocking assignments and an async reset so outputs
    // clear immediately on rst_n without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_MANUAL;
            ptr      <= '0;
            bus.y    <= '0;
            bus.ch   <= '0;
            bus.en   <= '0;
            bus.tick <= 1'b0;
        end else begin
            bus.y    <= bus.data_in[ptr*WIDTH +: WIDTH];
            bus.ch   <= ptr;
            bus.en   <= (state == S_BLANK) ? '0 : CHANNELS'(onehot(MAX_SELW'(ptr)));
            bus.tick <= advance;

            case (state)
                S_MANUAL: begin
                    if (!to_manual) begin
                        state <= S_SHOW;
                    end else if (sel_ok) begin
                        ptr <= bus.sel;
                    end
                end
                S_SHOW: begin
                    if (to_manual) begin
                        state <= S_MANUAL;
                        if (sel_ok) ptr <= bus.sel;
                    end else if (advance) begin
                        ptr   <= next_ptr;
                        state <= (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;
                    end
                end
                S_BLANK: begin
                    if (to_manual) begin
                        state <= S_MANUAL;
                        if (sel_ok) ptr <= bus.sel;
                    end else if (done) begin
                        state <= S_SHOW;
                    end
                end
                default: state <= S_MANUAL;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed plus random checks of two bcd_scan_mux instances against a
// slot-position reference model (4ch/3/1 with gap, 3ch/2/0 without gap).
module tb_bcd_scan_mux;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_scan_mux_if #(.WIDTH(4), .CHANNELS(4)) bus0 ();
    bcd_scan_mux_if #(.WIDTH(4), .CHANNELS(3)) bus1 ();

    bcd_scan_mux #(.WIDTH(4), .CHANNELS(4), .PRESCALE(3), .BLANK_CYCLES(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    bcd_scan_mux #(.WIDTH(4), .CHANNELS(3), .PRESCALE(2), .BLANK_CYCLES(0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each instance is either manual or scanning; when
    // scanning, pos walks 0..PRESCALE+BLANK-1 with pos >= PRESCALE blanked.
    bit          m_scan [2];
    int          m_ptr  [2];
    int          m_pos  [2];
    logic [15:0] e_y    [2];
    logic [15:0] e_ch   [2];
    logic [15:0] e_en   [2];
    logic [15:0] e_tick [2];

    function automatic int p_ch(input int k);
        return (k == 0) ? 4 : 3;
    endfunction
    function automatic int p_ps(input int k);
        return (k == 0) ? 3 : 2;
    endfunction
    function automatic int p_bl(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_scan[k] = 1'b0;
        m_ptr[k]  = 0;
        m_pos[k]  = 0;
        e_y[k]    = '0;
        e_ch[k]   = '0;
        e_en[k]   = '0;
        e_tick[k] = '0;
    endtask

    task automatic model_step(input int k);
        logic        md;
        logic        hd;
        int          s;
        logic [15:0] d;
        int          ch = p_ch(k);
        int          ps = p_ps(k);
        int          bl = p_bl(k);
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        if (k == 0) begin
            md = bus0.mode; hd = bus0.hold; s = int'(bus0.sel); d = bus0.data_in;
        end else begin
            md = bus1.mode; hd = bus1.hold; s = int'(bus1.sel); d = {4'h0, bus1.data_in};
        end
        e_y[k]    = (d >> (4 * m_ptr[k])) & 16'h000f;
        e_ch[k]   = 16'(m_ptr[k]);
        e_en[k]   = (m_scan[k] && m_pos[k] >= ps) ? 16'h0 : (16'h1 << m_ptr[k]);
        e_tick[k] = 16'(m_scan[k] && md && !hd && m_pos[k] == ps - 1);
        if (!m_scan[k]) begin
            if (md) begin
                m_scan[k] = 1'b1;
                m_pos[k]  = 0;
            end else if (s < ch) begin
                m_ptr[k] = s;
            end
        end else if (!md) begin
            m_scan[k] = 1'b0;
            m_pos[k]  = 0;
            if (s < ch) m_ptr[k] = s;
        end else if (!(hd && m_pos[k] < ps)) begin
            m_pos[k]++;
            if (m_pos[k] == ps) m_ptr[k] = (m_ptr[k] + 1) % ch;
            if (m_pos[k] == ps + bl) m_pos[k] = 0;
        end
    endtask

    task automatic compare_all();
        check("y0",    16'(bus0.y),    e_y[0]);
        check("ch0",   16'(bus0.ch),   e_ch[0]);
        check("en0",   16'(bus0.en),   e_en[0]);
        check("tick0", 16'(bus0.tick), e_tick[0]);
        check("y1",    16'(bus1.y),    e_y[1]);
        check("ch1",   16'(bus1.ch),   e_ch[1]);
        check("en1",   16'(bus1.en),   e_en[1]);
        check("tick1", 16'(bus1.tick), e_tick[1]);
    endtask

    // NOTE: inputs change 1 time unit after the edge and outputs are compared
    // there too, so neither races the DUT's registers.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic wait_en0(input logic [3:0] target, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cycle();
            hit = (bus0.en == target);
        end
        check(tag, 16'(hit), 16'h1);
    endtask

    task automatic wait_blank0(input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cycle();
            hit = m_scan[0] && (m_pos[0] == 3);
        end
        check(tag, 16'(hit), 16'h1);
    endtask

    initial begin
        int ticks;
        int shown;

        rst_n        = 1'b0;
        bus0.mode    = 1'b0;
        bus0.sel     = 2'd2;
        bus0.hold    = 1'b0;
        bus0.data_in = 16'h4321;
        bus1.mode    = 1'b0;
        bus1.sel     = 2'd1;
        bus1.hold    = 1'b0;
        bus1.data_in = 12'h321;
        model_reset(0);
        model_reset(1);

        #1;
        check("por_y",    16'(bus0.y),    16'h0);
        check("por_ch",   16'(bus0.ch),   16'h0);
        check("por_en",   16'(bus0.en),   16'h0);
        check("por_tick", 16'(bus0.tick), 16'h0);
        cycle();
        cycle();

        // Manual select after reset release.
        rst_n = 1'b1;
        cycle();
        cycle();
        check("man_y",    16'(bus0.y),    16'h3);
        check("man_ch",   16'(bus0.ch),   16'h2);
        check("man_en",   16'(bus0.en),   16'h4);
        check("man_tick", 16'(bus0.tick), 16'h0);

        // Out-of-range select is ignored on the three-channel instance.
        bus1.sel = 2'd3;
        repeat (3) cycle();
        check("oor_y",  16'(bus1.y),  16'h2);
        check("oor_ch", 16'(bus1.ch), 16'h1);
        check("oor_en", 16'(bus1.en), 16'h2);

        // Scan from channel 0: four advances per 16-cycle period.
        bus0.sel = 2'd0;
        cycle();
        bus0.mode = 1'b1;
        cycle();
        ticks = 0;
        repeat (16) begin
            cycle();
            ticks += int'(bus0.tick);
        end
        check("scan_ticks", 16'(ticks), 16'd4);

        // Hold freezes channel 1 for the whole hold window.
        wait_en0(4'b0001, "wait_ch0");
        wait_en0(4'b0010, "wait_ch1");
        bus0.hold = 1'b1;
        ticks = 0;
        shown = 0;
        repeat (10) begin
            cycle();
            ticks += int'(bus0.tick);
            shown += int'(bus0.en == 4'b0010);
        end
        bus0.hold = 1'b0;
        check("hold_en",   16'(shown), 16'd10);
        check("hold_tick", 16'(ticks), 16'd0);

        // Hold during the blank gap does not stretch it.
        wait_blank0("wait_blank_a");
        bus0.hold = 1'b1;
        cycle();
        check("hblank_en", 16'(bus0.en), 16'h0);
        bus0.hold = 1'b0;
        cycle();
        check("hblank_len", 16'(bus0.en != 4'b0000), 16'h1);

        // Mode switch to manual from inside the blank gap.
        wait_blank0("wait_blank_b");
        bus0.mode = 1'b0;
        bus0.sel  = 2'd3;
        cycle();
        check("ms_gap_en", 16'(bus0.en), 16'h0);
        cycle();
        check("ms_y",    16'(bus0.y),    16'h4);
        check("ms_ch",   16'(bus0.ch),   16'h3);
        check("ms_en",   16'(bus0.en),   16'h8);
        check("ms_tick", 16'(bus0.tick), 16'h0);
        bus0.mode = 1'b1;
        repeat (6) cycle();
        check("ms_wrap_ch", 16'(bus0.ch), 16'h0);
        check("ms_wrap_en", 16'(bus0.en), 16'h1);

        // Asynchronous reset between edges while channel 2 is shown.
        wait_en0(4'b0100, "wait_ch2");
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_y",    16'(bus0.y),    16'h0);
        check("areset_ch",   16'(bus0.ch),   16'h0);
        check("areset_en",   16'(bus0.en),   16'h0);
        check("areset_tick", 16'(bus0.tick), 16'h0);
        model_reset(0);
        model_reset(1);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("restart_ch", 16'(bus0.ch), 16'h0);
        check("restart_en", 16'(bus0.en), 16'h1);

        // Random traffic on both instances, including occasional resets.
        repeat (400) begin
            rst_n        = ($urandom_range(0, 63) != 0);
            bus0.mode    = ($urandom_range(0, 7) != 0);
            bus0.sel     = 2'($urandom_range(0, 3));
            bus0.hold    = ($urandom_range(0, 3) == 0);
            bus0.data_in = 16'($urandom);
            bus1.mode    = ($urandom_range(0, 7) != 0);
            bus1.sel     = 2'($urandom_range(0, 3));
            bus1.hold    = ($urandom_range(0, 3) == 0);
            bus1.data_in = 12'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
